// File: rtl/pattern_seq_ctrl.sv
// Two-requester sequencer: arbitrates, serializes the granted word MSB-first and counts overlapping pattern matches.
// Optional feature: define PATTERN_SEQ_RR_EN for round-robin arbitration (fixed priority to channel 0 otherwise).
module pattern_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              busy,
    output logic              res_valid,
    output logic              res_ch,
    output logic [CNT_W-1:0]  res_count
);

    localparam int HW = (PAT_W > 1) ? PAT_W - 1 : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              idle_s;
    logic              accept_s;
    logic              last_bit_s;
    logic              match_s;
    logic [DATA_W-1:0] data_s;
    logic [PAT_W-1:0]  window_s;
    logic [DATA_W-1:0] sreg_r;
    logic [PAT_W-1:0]  pat_r;
    logic [HW-1:0]     hist_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ch_r;
    logic              ser_bit_r;
    logic              ser_valid_r;
    logic              busy_r;
    logic              res_valid_r;
    logic              res_ch_r;
    logic [CNT_W-1:0]  res_count_r;

`ifdef PATTERN_SEQ_RR_EN
    logic last_grant_r;

    // Round-robin grant: on a tie the channel that did not win last time goes next.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    // Remember the last granted channel; reset value 1 lets channel 0 win the first tie.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
        end
    end
`else
    // Fixed priority grant: channel 0 always wins a tie.
    always_comb begin
        grant0_s = req0_valid;
        grant1_s = req1_valid & ~req0_valid;
    end
`endif

    // Handshake and job-control decode; ready never depends on the data inputs.
    always_comb begin
        idle_s     = n_rst && (state_r == IDLE);
        req0_ready = idle_s & grant0_s;
        req1_ready = idle_s & grant1_s;
        accept_s   = req0_ready | req1_ready;
        data_s     = grant1_s ? req1_data : req0_data;
        last_bit_s = (bit_cnt_r == CNT_W'(DATA_W - 1));
        window_s   = PAT_W'({hist_r, ser_bit_r});
        match_s    = (state_r == SHIFT) && (bit_cnt_r >= CNT_W'(PAT_W - 1)) && (window_s == pat_r);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SHIFT;
                else          state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (last_bit_s) state_nxt_s = REPORT;
                else            state_nxt_s = SHIFT;
            end
            REPORT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Datapath: job latch, shifter, history window, match counter and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg_r      <= '0;
            pat_r       <= '0;
            hist_r      <= '0;
            bit_cnt_r   <= '0;
            cnt_r       <= '0;
            ch_r        <= 1'b0;
            ser_bit_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_ch_r    <= 1'b0;
            res_count_r <= '0;
        end else begin
            ser_valid_r <= (state_nxt_s == SHIFT);
            busy_r      <= (state_nxt_s != IDLE);
            res_valid_r <= (state_nxt_s == REPORT);
            case (state_r)
                IDLE: begin
                    ser_bit_r <= 1'b0;
                    if (accept_s) begin
                        ser_bit_r <= data_s[DATA_W-1];
                        sreg_r    <= {data_s[DATA_W-2:0], 1'b0};
                        pat_r     <= pattern;
                        ch_r      <= grant1_s;
                        hist_r    <= '0;
                        bit_cnt_r <= '0;
                        cnt_r     <= '0;
                    end
                end
                SHIFT: begin
                    hist_r    <= HW'(window_s);
                    cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, match_s};
                    bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_bit_s) begin
                        ser_bit_r   <= 1'b0;
                        res_count_r <= cnt_r + {{(CNT_W-1){1'b0}}, match_s};
                        res_ch_r    <= ch_r;
                    end else begin
                        ser_bit_r <= sreg_r[DATA_W-1];
                        sreg_r    <= {sreg_r[DATA_W-2:0], 1'b0};
                    end
                end
                default: ser_bit_r <= 1'b0;
            endcase
        end
    end

    assign ser_bit   = ser_bit_r;
    assign ser_valid = ser_valid_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_ch    = res_ch_r;
    assign res_count = res_count_r;

endmodule
